// File: rtl/md_sequencer_pkg.sv
// Shared op codes, default latencies and FSM encodings for the multiply/divide sequencer.
// The controller encodes md_op from the same constants.
package md_sequencer_pkg;

    localparam logic [2:0] MD_MULTU = 3'b000;
    localparam logic [2:0] MD_MULT  = 3'b001;
    localparam logic [2:0] MD_DIVU  = 3'b010;
    localparam logic [2:0] MD_DIV   = 3'b011;
    localparam logic [2:0] MD_MADDU = 3'b100;
    localparam logic [2:0] MD_MADD  = 3'b101;

    localparam int MD_MUL_CYCLES_DEF = 5;
    localparam int MD_DIV_CYCLES_DEF = 10;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    function automatic logic is_div(input logic [2:0] op);
        return (op[2:1] == 2'b01);
    endfunction

endpackage

// File: rtl/md_arith.sv
// Combinational multiply/divide datapath producing the 64-bit {hi,lo} result.
// Accumulate (madd/maddu) path exists only when MD_MADD_EN is defined.
module md_arith
    import md_sequencer_pkg::*;
(
    input  logic [2:0]  md_op,
    input  logic [31:0] rs,
    input  logic [31:0] rt,
    input  logic [31:0] hi,
    input  logic [31:0] lo,
    output logic [63:0] result,
    output logic        div_by_zero
);

    logic signed [63:0] rs_s;
    logic signed [63:0] rt_s;
    logic signed [63:0] prod_s;
    logic        [63:0] prod_u;
    logic        [31:0] rt_nz;
    logic signed [31:0] quo_s;
    logic signed [31:0] rem_s;
    logic        [31:0] quo_u;
    logic        [31:0] rem_u;

    assign rs_s   = {{32{rs[31]}}, rs};
    assign rt_s   = {{32{rt[31]}}, rt};
    assign prod_s = rs_s * rt_s;
    assign prod_u = {32'd0, rs} * {32'd0, rt};

    // A zero divisor is swapped for 1 so the divider never sees an X-producing case;
    // the result is discarded at commit anyway.
    assign div_by_zero = (rt == 32'd0);
    assign rt_nz       = div_by_zero ? 32'd1 : rt;
    assign quo_s       = $signed(rs) / $signed(rt_nz);
    assign rem_s       = $signed(rs) % $signed(rt_nz);
    assign quo_u       = rs / rt_nz;
    assign rem_u       = rs % rt_nz;

`ifdef MD_MADD_EN
    logic [63:0] acc;
    assign acc = {hi, lo};
`else
    logic unused_acc;
    assign unused_acc = ^{hi, lo};
`endif

    always_comb begin
        result = 64'd0;
        case (md_op)
            MD_MULTU: result = prod_u;
            MD_MULT:  result = prod_s;
            MD_DIVU:  result = {rem_u, quo_u};
            MD_DIV:   result = {rem_s, quo_s};
`ifdef MD_MADD_EN
            MD_MADDU: result = acc + prod_u;
            MD_MADD:  result = acc + prod_s;
`endif
            default:  result = 64'd0;
        endcase
    end

endmodule

// File: rtl/md_sequencer.sv
// Multi-cycle mult/div sequencer owning HI/LO; latency is modelled with a down-counter.
// Optional MD_MADD_EN enables madd/maddu accumulate ops.
module md_sequencer
    import md_sequencer_pkg::*;
#(
    parameter int MUL_CYCLES = MD_MUL_CYCLES_DEF,
    parameter int DIV_CYCLES = MD_DIV_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        md_start,
    input  logic [2:0]  md_op,
    input  logic        md_we,
    input  logic        md_sel_lo,
    input  logic        md_rd_lo,
    input  logic        md_cancel,
    input  logic [31:0] rs_data,
    input  logic [31:0] rt_data,
    output logic        md_busy,
    output logic [31:0] md_rdata,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int MAX_CYC = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CYC) + 1;
    localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES - 1);
    localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES - 1);

    logic [0:0]       state;
    logic [CNT_W-1:0] cnt;
    logic [63:0]      res_p0;
    logic             dz_p0;
    logic [63:0]      arith_res;
    logic             arith_dz;
    logic             op_legal;
    logic             start_go;
    logic             wr_go;
    logic             commit;

`ifdef MD_MADD_EN
    assign op_legal = ~(md_op[2] & md_op[1]);
`else
    assign op_legal = ~md_op[2];
`endif

    assign start_go = (state == ST_IDLE) & md_start & ~md_cancel & op_legal;
    assign wr_go    = (state == ST_IDLE) & md_we & ~md_cancel & ~start_go;
    assign commit   = (state == ST_RUN) & (cnt == '0);
    assign md_busy  = (state == ST_RUN);
    assign md_rdata = md_rd_lo ? lo : hi;

    md_arith u_arith (
        .md_op       (md_op),
        .rs          (rs_data),
        .rt          (rt_data),
        .hi          (hi),
        .lo          (lo),
        .result      (arith_res),
        .div_by_zero (arith_dz)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else if (start_go) begin
            state <= ST_RUN;
            cnt   <= is_div(md_op) ? DIV_LOAD : MUL_LOAD;
        end else if (commit) begin
            state <= ST_IDLE;
        end else if (state == ST_RUN) begin
            cnt <= cnt - 1'b1;
        end
    end

    // Start edge: operands and (for madd) hi/lo are captured into the shadow here.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            res_p0 <= '0;
            dz_p0  <= 1'b0;
        end else if (start_go) begin
            res_p0 <= arith_res;
            dz_p0  <= is_div(md_op) & arith_dz;
        end
    end

    // Commit edge: shadow to architectural HI/LO, or an mthi/mtlo write while idle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hi <= '0;
            lo <= '0;
        end else if (commit) begin
            if (!dz_p0) begin
                hi <= res_p0[63:32];
                lo <= res_p0[31:0];
            end
        end else if (wr_go) begin
            if (md_sel_lo) lo <= rs_data;
            else           hi <= rs_data;
        end
    end

endmodule

// File: tb/tb_md_sequencer.sv
// Directed self-checking bench for md_sequencer (default latencies 5/10).
module tb_md_sequencer;
    import md_sequencer_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        md_start;
    logic [2:0]  md_op;
    logic        md_we;
    logic        md_sel_lo;
    logic        md_rd_lo;
    logic        md_cancel;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic        md_busy;
    logic [31:0] md_rdata;
    logic [31:0] hi;
    logic [31:0] lo;

    int total = 0;
    int bad   = 0;

    md_sequencer dut (
        .clk       (clk),
        .reset     (reset),
        .md_start  (md_start),
        .md_op     (md_op),
        .md_we     (md_we),
        .md_sel_lo (md_sel_lo),
        .md_rd_lo  (md_rd_lo),
        .md_cancel (md_cancel),
        .rs_data   (rs_data),
        .rt_data   (rt_data),
        .md_busy   (md_busy),
        .md_rdata  (md_rdata),
        .hi        (hi),
        .lo        (lo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Pulses md_start for one edge; inputs change on the falling edge.
    task automatic start_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                            input logic cancel);
        @(negedge clk);
        md_start  = 1'b1;
        md_op     = op;
        rs_data   = a;
        rt_data   = b;
        md_cancel = cancel;
        @(negedge clk);
        md_start  = 1'b0;
        md_cancel = 1'b0;
    endtask

    // Counts busy cycles, bounded so a stuck busy cannot hang the run.
    task automatic count_busy(output int n);
        n = 0;
        while (md_busy && n < 100) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic write_md(input logic sel_lo, input logic [31:0] v, input logic cancel);
        @(negedge clk);
        md_we     = 1'b1;
        md_sel_lo = sel_lo;
        rs_data   = v;
        md_cancel = cancel;
        @(negedge clk);
        md_we     = 1'b0;
        md_cancel = 1'b0;
    endtask

    initial begin
        int n;
        reset = 1'b1; md_start = 1'b0; md_op = 3'b000; md_we = 1'b0; md_sel_lo = 1'b0;
        md_rd_lo = 1'b0; md_cancel = 1'b0; rs_data = '0; rt_data = '0;
        repeat (2) @(negedge clk);
        chk("rst_busy", 64'(md_busy), 64'd0);
        chk("rst_hi", 64'(hi), 64'd0);
        chk("rst_lo", 64'(lo), 64'd0);
        reset = 1'b0;

        // mult -3 * 5
        start_op(MD_MULT, 32'hFFFFFFFD, 32'h00000005, 1'b0);
        count_busy(n);
        chk("mult_busy", 64'(n), 64'd5);
        chk("mult_hi", 64'(hi), 64'hFFFFFFFF);
        chk("mult_lo", 64'(lo), 64'hFFFFFFF1);

        // multu max * max
        start_op(MD_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
        count_busy(n);
        chk("multu_res", {hi, lo}, 64'hFFFFFFFE_00000001);

        // divu 7/2
        start_op(MD_DIVU, 32'd7, 32'd2, 1'b0);
        count_busy(n);
        chk("divu_busy", 64'(n), 64'd10);
        chk("divu_lo", 64'(lo), 64'd3);
        chk("divu_hi", 64'(hi), 64'd1);

        // div -7/2
        start_op(MD_DIV, 32'hFFFFFFF9, 32'd2, 1'b0);
        count_busy(n);
        chk("div_lo", 64'(lo), 64'hFFFFFFFD);
        chk("div_hi", 64'(hi), 64'hFFFFFFFF);
        md_rd_lo = 1'b1; #1;
        chk("rdata_lo", 64'(md_rdata), 64'hFFFFFFFD);
        md_rd_lo = 1'b0; #1;
        chk("rdata_hi", 64'(md_rdata), 64'hFFFFFFFF);

        // mthi then divide by zero
        write_md(1'b0, 32'h12345678, 1'b0);
        chk("mthi", 64'(hi), 64'h12345678);
        start_op(MD_DIV, 32'd9, 32'd0, 1'b0);
        count_busy(n);
        chk("dz_busy", 64'(n), 64'd10);
        chk("dz_hi", 64'(hi), 64'h12345678);
        chk("dz_lo", 64'(lo), 64'hFFFFFFFD);

        // cancelled start and cancelled write
        start_op(MD_MULT, 32'd2, 32'd3, 1'b1);
        chk("cancel_busy", 64'(md_busy), 64'd0);
        chk("cancel_hilo", {hi, lo}, 64'h12345678_FFFFFFFD);
        write_md(1'b1, 32'hCAFEF00D, 1'b1);
        chk("cancel_wr", 64'(lo), 64'hFFFFFFFD);

        // illegal op 110, and 101 when accumulate is not built
        start_op(3'b110, 32'd2, 32'd3, 1'b0);
        chk("illegal_busy", 64'(md_busy), 64'd0);
`ifndef MD_MADD_EN
        start_op(MD_MADD, 32'd2, 32'd3, 1'b0);
        chk("nomadd_busy", 64'(md_busy), 64'd0);
`endif

        // mtlo while busy dropped; second start during RUN ignored
        start_op(MD_MULT, 32'd2, 32'd3, 1'b0);
        md_we = 1'b1; md_sel_lo = 1'b1; rs_data = 32'hDEADBEEF;
        @(negedge clk);
        md_we = 1'b0;
        chk("wr_busy_drop", 64'(lo), 64'hFFFFFFFD);
        md_start = 1'b1; md_op = MD_DIVU; rs_data = 32'd100; rt_data = 32'd7;
        @(negedge clk);
        md_start = 1'b0;
        count_busy(n);
        chk("restart_busy", 64'(n + 2), 64'd5);
        chk("restart_res", {hi, lo}, 64'h00000000_00000006);

        // start and write together: start wins
        @(negedge clk);
        md_start = 1'b1; md_op = MD_MULT; rs_data = 32'd4; rt_data = 32'd4;
        md_we = 1'b1; md_sel_lo = 1'b1;
        @(negedge clk);
        md_start = 1'b0; md_we = 1'b0;
        chk("startwr_lo", 64'(lo), 64'd6);
        count_busy(n);
        chk("startwr_res", 64'(lo), 64'd16);

`ifdef MD_MADD_EN
        write_md(1'b1, 32'h0000000A, 1'b0);
        write_md(1'b0, 32'h00000000, 1'b0);
        start_op(MD_MADD, 32'd2, 32'd3, 1'b0);
        count_busy(n);
        chk("madd_busy", 64'(n), 64'd5);
        chk("madd_res", {hi, lo}, 64'h00000000_00000010);
`endif

        // async reset in busy cycle 4 of a divide
        start_op(MD_DIVU, 32'd7, 32'd2, 1'b0);
        repeat (3) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        chk("rstmid_busy", 64'(md_busy), 64'd0);
        chk("rstmid_hilo", {hi, lo}, 64'd0);
        @(negedge clk);
        reset = 1'b0;
        start_op(MD_MULT, 32'hFFFFFFFD, 32'h00000005, 1'b0);
        count_busy(n);
        chk("post_rst_busy", 64'(n), 64'd5);
        chk("post_rst_res", {hi, lo}, 64'hFFFFFFFF_FFFFFFF1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
